// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_csel_add.sv
// 4-bit carry-select add slice: both carry-in cases are summed, Cin picks one.
// Latency: combinational. Backpressure: none.
module nibble_csel_add
  import nsa_pkg::*;
(
  input  logic [NIBBLE-1:0] A,
  input  logic [NIBBLE-1:0] B,
  input  logic              Cin,
  output logic [NIBBLE-1:0] S,
  output logic              Cout
);

  logic [NIBBLE:0] sum_c0;
  logic [NIBBLE:0] sum_c1;

  assign sum_c0 = {1'b0, A} + {1'b0, B};
  assign sum_c1 = {1'b0, A} + {1'b0, B} + {{NIBBLE{1'b0}}, 1'b1};

  assign S    = Cin ? sum_c1[NIBBLE-1:0] : sum_c0[NIBBLE-1:0];
  assign Cout = Cin ? sum_c1[NIBBLE]     : sum_c0[NIBBLE];

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder, one nibble per clock through one carry-select slice; SUB_EN adds A-B.
// Latency: Done N=WIDTH/4 cycles after the accepting edge. Backpressure: Start ignored while Busy.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int N        = WIDTH / NIBBLE;
  localparam int CNT_W    = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_t             state_q, state_d;
  logic               accept;
  logic               last_nib;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_sh, b_sh, sum_sh;
  logic               carry_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic [NIBBLE-1:0]  slice_s;
  logic               slice_c;
  logic [WIDTH-1:0]   b_in;
  logic               cin_in;
  logic [WIDTH-1:0]   sum_next;

`ifdef SUB_EN
  // Two's-complement subtract: invert B and inject a carry of one.
  assign b_in   = Sub ? ~B : B;
  assign cin_in = Sub ? 1'b1 : Cin;
`else
  assign b_in   = B;
  assign cin_in = Cin;
`endif

  nibble_csel_add u_slice (
    .A    (a_sh[NIBBLE-1:0]),
    .B    (b_sh[NIBBLE-1:0]),
    .Cin  (carry_q),
    .S    (slice_s),
    .Cout (slice_c)
  );

  assign sum_next = {slice_s, sum_sh[WIDTH-1:NIBBLE]};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_nib = 1'b0;
    case (state_q)
      IDLE: if (Start) begin
        state_d = RUN;
        accept  = 1'b1;
      end
      RUN: if (cnt_q == LAST_CNT) begin
        state_d  = DONE;
        last_nib = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q   <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      a_sh    <= A;
      b_sh    <= b_in;
      sum_sh  <= '0;
      carry_q <= cin_in;
    end else if (state_q == RUN) begin
      cnt_q   <= cnt_q + CNT_W'(1);
      a_sh    <= a_sh >> NIBBLE;
      b_sh    <= b_sh >> NIBBLE;
      sum_sh  <= sum_next;
      carry_q <= slice_c;
      // Outputs change only as the last nibble completes, never with partial sums.
      if (last_nib) begin
        sum_q  <= sum_next;
        cout_q <= slice_c;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
`ifdef SUB_EN
  logic        Sub;
`endif
  logic        Busy;
  logic        Done;
  logic [15:0] Sum;
  logic        Cout;

  int checks   = 0;
  int failures = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Cin     (Cin),
`ifdef SUB_EN
    .Sub     (Sub),
`endif
    .Busy    (Busy),
    .Done    (Done),
    .Sum     (Sum),
    .Cout    (Cout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept on one edge, then check Done timing (edge k+4), result and return to IDLE.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] exp_sum, input logic exp_cout);
    @(negedge Clk);
    A = a; B = b; Cin = cin; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk({tag, " busy_after_accept"}, 16'(Busy), 16'd1);
    for (int i = 1; i < 4; i++) begin
      @(posedge Clk); #1;
      chk({tag, " done_early"}, 16'(Done), 16'd0);
    end
    @(posedge Clk); #1;
    chk({tag, " done"}, 16'(Done), 16'd1);
    chk({tag, " sum"},  Sum, exp_sum);
    chk({tag, " cout"}, 16'(Cout), 16'(exp_cout));
    @(posedge Clk); #1;
    chk({tag, " done_pulse_end"}, 16'(Done), 16'd0);
    chk({tag, " busy_end"},       16'(Busy), 16'd0);
  endtask

  initial begin
    Reset_n = 1'b1; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
`ifdef SUB_EN
    Sub = 1'b0;
`endif
    #1 Reset_n = 1'b0;
    #1;
    chk("por sum",  Sum, 16'h0000);
    chk("por busy", 16'(Busy), 16'd0);
    chk("por done", 16'(Done), 16'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset_n = 1'b1;

    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);

    // Mid-cycle reset must clear outputs without any clock edge.
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst sum",  Sum, 16'h0000);
    chk("async_rst cout", 16'(Cout), 16'd0);
    chk("async_rst busy", 16'(Busy), 16'd0);
    chk("async_rst done", 16'(Done), 16'd0);
    @(negedge Clk) Reset_n = 1'b1;

    run_op("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_op("cin_chain",   16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run_op("no_carry",    16'h89AB, 16'h7654, 1'b0, 16'hFFFF, 1'b0);

    // Start re-asserted during RUN with new A is ignored; held high, it re-accepts at k+6.
    @(negedge Clk);
    A = 16'h0F0F; B = 16'h0101; Cin = 1'b0; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(negedge Clk);
    A = 16'hAAAA; Start = 1'b1;
    repeat (3) @(posedge Clk);
    @(posedge Clk); #1;
    chk("ignore done", 16'(Done), 16'd1);
    chk("ignore sum",  Sum, 16'h1010);
    chk("ignore cout", 16'(Cout), 16'd0);
    @(posedge Clk); #1;
    chk("held idle busy", 16'(Busy), 16'd0);
    @(posedge Clk); #1;
    chk("held reaccept busy", 16'(Busy), 16'd1);
    Start = 1'b0;
    @(posedge Clk); #1;
    chk("sum held in run", Sum, 16'h1010);
    repeat (2) @(posedge Clk);
    @(posedge Clk); #1;
    chk("second done", 16'(Done), 16'd1);
    chk("second sum",  Sum, 16'hABAB);
    chk("second cout", 16'(Cout), 16'd0);
    @(posedge Clk); #1;

    // Reset in the second RUN cycle discards the operation.
    @(negedge Clk);
    A = 16'h8000; B = 16'h8000; Cin = 1'b0; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #3;
    Reset_n = 1'b0;
    #1;
    chk("run_rst sum",  Sum, 16'h0000);
    chk("run_rst cout", 16'(Cout), 16'd0);
    chk("run_rst busy", 16'(Busy), 16'd0);
    chk("run_rst done", 16'(Done), 16'd0);
    @(negedge Clk) Reset_n = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    chk("run_rst no_resume done", 16'(Done), 16'd0);
    chk("run_rst no_resume busy", 16'(Busy), 16'd0);
    run_op("after_rst", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

`ifdef SUB_EN
    Sub = 1'b1;
    run_op("sub_borrow",    16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    run_op("sub_no_borrow", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
    Sub = 1'b0;
    run_op("sub_off_add",   16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
